// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// widths, and the common hazard-resolution rules used from several states.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_CNT_W = 8;
  localparam int unsigned BR_TIMEOUT  = 4;
  localparam int unsigned WAIT_CNT_W  = 2;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StBrWait  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic        stall;
    pipe_state_e next;
  } run_decision_t;

  // Hazard priority applied in RUN, in LD_STALL (load_use masked) and on a
  // not-taken branch resolution.
  function automatic run_decision_t run_rules(input logic load_use,
                                              input logic br_in_id,
                                              input logic flag_write,
                                              input logic mem_read);
    run_decision_t d;
    d.stall = 1'b0;
    d.next  = StRun;
    if (load_use) begin
      d.stall = 1'b1;
      d.next  = StLdStall;
    end else if (br_in_id && (flag_write || mem_read)) begin
      d.stall = 1'b1;
    end else if (br_in_id) begin
      d.next = StBrWait;
    end
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MaxVal = '1;

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MaxVal)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch-behind-flag stalls,
// branch resolution wait with redirect/flush and a sticky resolve timeout.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_use,
  input  logic                   br_in_id,
  input  logic                   IDEX_flagWrite1,
  input  logic                   EXMEM_MemRead,
  input  logic                   br_resolve,
  input  logic                   br_taken,
  output logic                   PCWrite,
  output logic                   IFWrite,
  output logic                   IDEX_ctrl_flush,
  output logic                   IFID_flush,
  output logic                   pc_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   br_timeout,
  output logic [1:0]             state
);

  localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'(BR_TIMEOUT - 1);

  pipe_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  stall;
  run_decision_t         dec;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_d       = timeout_q;
    stall           = 1'b0;
    dec             = '{stall: 1'b0, next: StRun};
    PCWrite         = 1'b1;
    IFWrite         = 1'b1;
    IDEX_ctrl_flush = 1'b0;
    IFID_flush      = 1'b0;
    pc_sel          = 1'b0;

    unique case (state_q)
      StRun: begin
        dec     = run_rules(load_use, br_in_id, IDEX_flagWrite1, EXMEM_MemRead);
        stall   = dec.stall;
        state_d = dec.next;
      end
      StLdStall: begin
        // The load bubble has already been inserted; never stall twice for it.
        dec     = run_rules(1'b0, br_in_id, IDEX_flagWrite1, EXMEM_MemRead);
        stall   = dec.stall;
        state_d = dec.next;
      end
      StBrWait: begin
        if (!br_resolve) begin
          if (wait_cnt_q == WaitLast) begin
            timeout_d = 1'b1;
            state_d   = StRun;
          end else begin
            stall      = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end else if (br_taken) begin
          pc_sel     = 1'b1;
          IFID_flush = 1'b1;
          state_d    = StRun;
        end else begin
          dec     = run_rules(load_use, br_in_id, IDEX_flagWrite1, EXMEM_MemRead);
          stall   = dec.stall;
          state_d = dec.next;
        end
      end
      default: state_d = StRun;
    endcase

    // Any branch freshly decoded into BR_WAIT starts a new wait window.
    if (dec.next == StBrWait) begin
      wait_cnt_d = '0;
    end

    if (stall) begin
      PCWrite         = 1'b0;
      IFWrite         = 1'b0;
      IDEX_ctrl_flush = 1'b1;
    end

    if (reset) begin
      PCWrite         = 1'b0;
      IFWrite         = 1'b0;
      IDEX_ctrl_flush = 1'b1;
      IFID_flush      = 1'b1;
      pc_sel          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  sat_counter #(
    .Width(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (IDEX_ctrl_flush & ~reset),
    .count(stall_cnt)
  );

  assign br_timeout = timeout_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_use, br_in_id, flag_wr, mem_rd, br_resolve, br_taken;
  logic       PCWrite, IFWrite, IDEX_ctrl_flush, IFID_flush, pc_sel, br_timeout;
  logic [7:0] stall_cnt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .load_use       (load_use),
    .br_in_id       (br_in_id),
    .IDEX_flagWrite1(flag_wr),
    .EXMEM_MemRead  (mem_rd),
    .br_resolve     (br_resolve),
    .br_taken       (br_taken),
    .PCWrite        (PCWrite),
    .IFWrite        (IFWrite),
    .IDEX_ctrl_flush(IDEX_ctrl_flush),
    .IFID_flush     (IFID_flush),
    .pc_sel         (pc_sel),
    .stall_cnt      (stall_cnt),
    .br_timeout     (br_timeout),
    .state          (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic fl, input logic mr,
                       input logic res, input logic tk);
    load_use   = lu;
    br_in_id   = br;
    flag_wr    = fl;
    mem_rd     = mr;
    br_resolve = res;
    br_taken   = tk;
  endtask

  // Move to mid-cycle (combinational outputs settled, away from edges).
  task automatic mid();
    #4;
  endtask

  // Advance through the next rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_pcw"}, 32'(PCWrite), 32'(!exp));
    check({tag, "_ifw"}, 32'(IFWrite), 32'(!exp));
    check({tag, "_flush"}, 32'(IDEX_ctrl_flush), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    mid();
    check("rst_pcw", 32'(PCWrite), 0);
    check("rst_ifw", 32'(IFWrite), 0);
    check("rst_flush", 32'(IDEX_ctrl_flush), 1);
    check("rst_ifid", 32'(IFID_flush), 1);
    check("rst_pcsel", 32'(pc_sel), 0);
    check("rst_state", 32'(state), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    check("rst_to", 32'(br_timeout), 0);
    tick();
    check("rst_cnt_hold", 32'(stall_cnt), 0);

    // Idle run: default outputs
    reset = 1'b0;
    mid();
    check_stall("idle", 1'b0);
    check("idle_ifid", 32'(IFID_flush), 0);
    tick();

    // Load-use held two cycles -> exactly one bubble
    drive(1, 0, 0, 0, 0, 0);
    mid();
    check_stall("lu1", 1'b1);
    tick();
    check("lu1_state", 32'(state), 1);
    check("lu1_cnt", 32'(stall_cnt), 1);
    mid();
    check_stall("lu2", 1'b0);
    tick();
    check("lu2_state", 32'(state), 0);
    check("lu2_cnt", 32'(stall_cnt), 1);

    // Branch behind flag setter: stall one cycle, then BR_WAIT, then taken
    drive(0, 1, 1, 0, 0, 0);
    mid();
    check_stall("brf", 1'b1);
    tick();
    check("brf_state", 32'(state), 0);
    check("brf_cnt", 32'(stall_cnt), 2);
    drive(0, 1, 0, 0, 0, 0);
    mid();
    check_stall("br_go", 1'b0);
    tick();
    check("br_go_state", 32'(state), 2);
    drive(0, 0, 0, 0, 1, 1);
    mid();
    check("tk_pcsel", 32'(pc_sel), 1);
    check("tk_ifid", 32'(IFID_flush), 1);
    check("tk_pcw", 32'(PCWrite), 1);
    check("tk_flush", 32'(IDEX_ctrl_flush), 0);
    tick();
    check("tk_state", 32'(state), 0);

    // Branch behind a load in MEM stalls in place
    drive(0, 1, 0, 1, 0, 0);
    mid();
    check_stall("brm", 1'b1);
    tick();
    check("brm_state", 32'(state), 0);
    check("brm_cnt", 32'(stall_cnt), 3);

    // Not-taken resolution with load_use honoured
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("nt_enter", 32'(state), 2);
    drive(1, 0, 0, 0, 1, 0);
    mid();
    check_stall("nt_lu", 1'b1);
    check("nt_pcsel", 32'(pc_sel), 0);
    check("nt_ifid", 32'(IFID_flush), 0);
    tick();
    check("nt_state", 32'(state), 1);
    check("nt_cnt", 32'(stall_cnt), 4);
    // br_resolve outside BR_WAIT is ignored
    drive(0, 0, 0, 0, 1, 1);
    mid();
    check("ign_pcsel", 32'(pc_sel), 0);
    check("ign_ifid", 32'(IFID_flush), 0);
    tick();
    check("ign_state", 32'(state), 0);

    // Timeout: three stall cycles then sticky br_timeout
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("to_enter", 32'(state), 2);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mid();
      check_stall("to_wait", 1'b1);
      tick();
      check("to_wait_state", 32'(state), 2);
    end
    mid();
    check_stall("to_last", 1'b0);
    check("to_last_pcsel", 32'(pc_sel), 0);
    tick();
    check("to_state", 32'(state), 0);
    check("to_flag", 32'(br_timeout), 1);
    check("to_cnt", 32'(stall_cnt), 7);
    repeat (10) tick();
    check("to_sticky", 32'(br_timeout), 1);

    // Re-entry clears the wait counter: first cycle must stall again
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    mid();
    check_stall("reent", 1'b1);
    tick();
    check("reent_state", 32'(state), 2);
    drive(0, 0, 0, 0, 1, 1);
    tick();
    check("reent_exit", 32'(state), 0);

    // Saturation after 300 bubbles
    drive(0, 1, 1, 0, 0, 0);
    repeat (300) tick();
    check("sat_cnt", 32'(stall_cnt), 255);
    check("sat_state", 32'(state), 0);

    // Reset during BR_WAIT abandons the branch
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("rbw_state", 32'(state), 2);
    drive(0, 0, 0, 0, 1, 1);
    reset = 1'b1;
    mid();
    check("rbw_pcsel", 32'(pc_sel), 0);
    check("rbw_pcw", 32'(PCWrite), 0);
    check("rbw_ifid", 32'(IFID_flush), 1);
    tick();
    check("rbw_state2", 32'(state), 0);
    check("rbw_cnt", 32'(stall_cnt), 0);
    check("rbw_to", 32'(br_timeout), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    mid();
    check_stall("post", 1'b0);
    check("post_pcsel", 32'(pc_sel), 0);
    tick();
    check("post_cnt", 32'(stall_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 load_use  input  1  load-use dependency detected on the instruction in ID.
REQ-005 br_in_id  input  1  branch (opcode 11010) in ID.
REQ-006 IDEX_flagWrite1  input  1  instruction in EX writes flags.
REQ-007 EXMEM_MemRead  input  1  load in MEM.
REQ-008 br_resolve  input  1  branch resolved in EX this cycle.
REQ-009 br_taken  input  1  resolved branch outcome; valid only with br_resolve.
REQ-010 PCWrite, IFWrite  output  1 each  PC and IF/ID register enables.
REQ-011 IDEX_ctrl_flush, IFID_flush  output  1 each  bubble into ID/EX; squash IF/ID.
REQ-012 pc_sel  output  1  1 selects the branch target for the next PC.
REQ-013 stall_cnt  output  8  saturating count of bubble cycles.
REQ-014 br_timeout  output  1  sticky branch-resolve timeout error.
REQ-015 state  output  2  current FSM state, for debug.

Function
REQ-016 States SHALL be RUN=0, LD_STALL=1, BR_WAIT=2; the state register updates on clk.
REQ-017 Outputs SHALL be combinational from state and inputs; default PCWrite=IFWrite=1, all other 1-bit outputs 0.
REQ-018 A stall SHALL mean PCWrite=0, IFWrite=0 and IDEX_ctrl_flush=1 in the same cycle.
REQ-019 RUN priority SHALL be: load_use -> stall, next LD_STALL; else br_in_id & (IDEX_flagWrite1 | EXMEM_MemRead) -> stall, next RUN; else br_in_id -> no stall, next BR_WAIT; else next RUN.
REQ-020 LD_STALL SHALL apply the RUN rules with load_use masked to 0, then leave for the state those rules select; a load bubble is exactly one cycle.
REQ-021 BR_WAIT without br_resolve SHALL stall and increment a 2-bit wait counter.
REQ-022 BR_WAIT with br_resolve & br_taken SHALL assert pc_sel=1 and IFID_flush=1, keep PCWrite=1, ignore load_use and br_in_id, and go to RUN.
REQ-023 BR_WAIT with br_resolve & !br_taken SHALL apply the RUN rules in the same cycle, with load_use honoured.
REQ-024 On the 4th consecutive BR_WAIT cycle without br_resolve, the block SHALL set br_timeout=1 and go to RUN without redirecting.
REQ-025 br_timeout SHALL stay 1 until reset.
REQ-026 The wait counter SHALL clear on every entry to BR_WAIT.
REQ-027 br_resolve outside BR_WAIT SHALL be ignored.
REQ-028 stall_cnt SHALL increment on every cycle with IDEX_ctrl_flush=1 and saturate at 255 (no wrap).

Reset
REQ-029 While reset=1, outputs SHALL be PCWrite=0, IFWrite=0, IDEX_ctrl_flush=1, IFID_flush=1 and pc_sel=0.
REQ-030 While reset=1, stall_cnt SHALL not count reset cycles.
REQ-031 On the first clk edge with reset=1: state=RUN, wait counter=0, stall_cnt=0, br_timeout=0.
REQ-032 Reset while in BR_WAIT SHALL abandon the pending branch with no redirect.

Structure
REQ-033 Shared package pipe_ctrl_pkg SHALL hold the state encoding, STALL_CNT_W=8 and BR_TIMEOUT=4.
REQ-034 stall_cnt SHALL be implemented in one sub-module, sat_counter, parameterised by width.

Verification
REQ-035 Load-use stall: after reset, hold load_use=1 for 2 cycles -> one stall cycle; then state=LD_STALL with PCWrite=1; stall_cnt=1.
REQ-036 Branch behind flag setter: br_in_id=1, IDEX_flagWrite1=1 for 1 cycle, then flag=0 -> 1 stall, then state=BR_WAIT; next cycle br_resolve=1, br_taken=1 -> pc_sel=1, IFID_flush=1, state=RUN.
REQ-037 Not-taken with load_use: in BR_WAIT drive br_resolve=1, br_taken=0, load_use=1 -> stall, pc_sel=0, next LD_STALL.
REQ-038 Timeout: enter BR_WAIT and never resolve -> 3 stall cycles then br_timeout=1, state=RUN; br_timeout still 1 ten cycles later.
REQ-039 Saturation and reset: force 300 stall cycles -> stall_cnt=255; assert reset in BR_WAIT -> next cycle state=RUN, stall_cnt=0, pc_sel=0.
